vreg_file_stream: RTL
=====================

// Module: vreg_file_stream
// PURPOSE
//  Parametrised vector register file, NUM_VEC vectors x LANES elements x WIDTH bits.
//  One element-serial write port and two element-serial read ports (operands A/B).
//  All three streams share one clock, with explicit start/valid/done handshakes.
//  Sits between the vector ALU and memory. Supports gapped streams and same-cycle read/write.
// PARAMETERS
//  WIDTH    16  bits per element
//  LANES    16  elements per vector (>=2); index width LW = $clog2(LANES)
//  NUM_VEC   8  number of vectors (>=2); address width AW = $clog2(NUM_VEC)
// PORTS
//  Clk        in   1      single clock, all state on posedge
//  Rst        in   1      synchronous, active-high reset
//  WrStart    in   1      begin write stream to vector WrAddr
//  WrAddr     in   AW     write target, sampled on accepted WrStart
//  WrValid    in   1      DataIn valid this cycle (element accepted)
//  DataIn     in   WIDTH  write element
//  WrBusy     out  1      write stream in progress
//  WrDone     out  1      1-cycle pulse: last element written
//  RdStart    in   1      begin read stream of RdAddr/RdAddr2
//  RdAddr     in   AW     operand A vector, sampled on accepted RdStart
//  RdAddr2    in   AW     operand B vector, sampled on accepted RdStart
//  RdEn       in   1      advance read stream this cycle (stall when low)
//  RdBusy     out  1      read stream in progress
//  DataOut    out  WIDTH  operand A element
//  DataOut2   out  WIDTH  operand B element
//  RdValid    out  1      DataOut/DataOut2 hold a new element this cycle
//  RdDone     out  1      1-cycle pulse, coincident with RdValid of element LANES-1
// BEHAVIOUR
//  Reset: all storage, element counters, WrBusy, WrDone, RdBusy, RdValid, RdDone,
//   DataOut and DataOut2 go to 0. An in-flight stream is aborted, no done pulse.
//  Write FSM WIDLE->WACT: WrStart while WIDLE latches WrAddr, clears wcnt, sets WrBusy next cycle.
//   WrStart while WACT is ignored. WrValid is ignored in WIDLE.
//   In WACT, each WrValid cycle writes DataIn to vec[wa][wcnt] and increments wcnt.
//   WrValid=0 is a stall: no write, wcnt unchanged.
//   Write at wcnt=LANES-1: WrDone=1 next cycle, WrBusy=0 next cycle, back to WIDLE.
//   Same cycle as WrStart: WrValid is not accepted (first element earliest next cycle).
//  Read FSM RIDLE->RACT: RdStart while RIDLE latches both addresses, clears rcnt.
//   RdStart while RACT is ignored.
//   In RACT, each RdEn cycle registers vec[ra][rcnt] to DataOut and vec[rb][rcnt] to DataOut2.
//   RdValid=1 on the next cycle; rcnt increments. Latency is 1 cycle, RdEn to data.
//   RdEn=0: RdValid=0 next cycle, DataOut/DataOut2 hold their last value.
//   Element LANES-1 read: RdDone=1 with its RdValid, RdBusy=0 that cycle, back to RIDLE.
//  Read/write collision (same vector, same element, same cycle): the read returns the OLD value.
//   The write lands at the clock edge. No bypass.
//  RdAddr==RdAddr2 is legal: both outputs are equal.
//  Write and read streams are fully independent and may overlap in any phase.
//  Counters never wrap past LANES-1. Termination forces the FSM back to idle.
//  No other storage changes. Out-of-range addresses (NUM_VEC not a power of 2) are undefined.
// TESTING
//  1 Reset; WrStart addr 0, 16 back-to-back WrValid with DataIn A000..A00F.
//    Then WrDone pulses once, 1 cycle after the 16th write.
//  2 Read vec0/vec0, RdEn held high: RdValid on 16 consecutive cycles.
//    Both outputs show A000..A00F; RdDone with A00F.
//  3 Write vec2 with gaps (WrValid 1,0,0,1,...): exactly 16 elements are stored, in order.
//    Then read vec2/vec0 with RdEn toggled: outputs hold during stalls, pairing stays correct.
//  4 Overlap: read vec2 while rewriting vec2 with B0xx, write one element ahead of read.
//    Each element is read as the old value on the collision cycle and the new value after.
//  5 Rst asserted at write element 7 and at read element 5: no done pulse.
//    All outputs 0 next cycle; a subsequent read returns 0000 everywhere.
//  6 WrStart/RdStart re-asserted mid-stream with a different address: ignored.
//    The stream completes to the original vector.

Source files
------------

// File: rtl/vreg_file_stream.sv
// Vector register file: NUM_VEC vectors of LANES elements, one element-serial write stream
// and one dual-operand element-serial read stream, each with its own start/busy/done handshake.
module vreg_file_stream #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 16,
  parameter int NUM_VEC = 8,
  localparam int LW = $clog2(LANES),
  localparam int AW = $clog2(NUM_VEC)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WrStart,
  input  logic [AW-1:0]    WrAddr,
  input  logic             WrValid,
  input  logic [WIDTH-1:0] DataIn,
  output logic             WrBusy,
  output logic             WrDone,
  input  logic             RdStart,
  input  logic [AW-1:0]    RdAddr,
  input  logic [AW-1:0]    RdAddr2,
  input  logic             RdEn,
  output logic             RdBusy,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] DataOut2,
  output logic             RdValid,
  output logic             RdDone
);

  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  typedef enum logic {WIDLE, WACT} wstate_t;
  typedef enum logic {RIDLE, RACT} rstate_t;

  logic [WIDTH-1:0] mem [NUM_VEC][LANES];

  wstate_t       wstate, wstate_nxt;
  logic [AW-1:0] wa;
  logic [LW-1:0] wcnt;
  logic          wr_fire, wr_last, wr_start_acc;

  rstate_t       rstate, rstate_nxt;
  logic [AW-1:0] ra, rb;
  logic [LW-1:0] rcnt;
  logic          rd_fire, rd_last, rd_start_acc;

  assign wr_start_acc = (wstate == WIDLE) && WrStart;
  assign rd_start_acc = (rstate == RIDLE) && RdStart;
  assign WrBusy       = (wstate == WACT);
  assign RdBusy       = (rstate == RACT);

  always_comb begin
    wstate_nxt = wstate;
    wr_fire    = 1'b0;
    wr_last    = 1'b0;
    unique case (wstate)
      WIDLE: if (WrStart) wstate_nxt = WACT;
      WACT: begin
        if (WrValid) begin
          wr_fire = 1'b1;
          if (wcnt == LAST) begin
            wr_last    = 1'b1;
            wstate_nxt = WIDLE;
          end
        end
      end
      default: wstate_nxt = WIDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wstate <= WIDLE;
      wa     <= '0;
      wcnt   <= '0;
      WrDone <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      WrDone <= wr_last;
      if (wr_start_acc) begin
        wa   <= WrAddr;
        wcnt <= '0;
      end else if (wr_fire) begin
        wcnt <= wr_last ? '0 : wcnt + 1'b1;
      end
    end
  end

  // Write lands at the edge, so a same-cycle read of the same element sees the old value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int v = 0; v < NUM_VEC; v++)
        for (int e = 0; e < LANES; e++)
          mem[v][e] <= '0;
    end else if (wr_fire) begin
      mem[wa][wcnt] <= DataIn;
    end
  end

  always_comb begin
    rstate_nxt = rstate;
    rd_fire    = 1'b0;
    rd_last    = 1'b0;
    unique case (rstate)
      RIDLE: if (RdStart) rstate_nxt = RACT;
      RACT: begin
        if (RdEn) begin
          rd_fire = 1'b1;
          if (rcnt == LAST) begin
            rd_last    = 1'b1;
            rstate_nxt = RIDLE;
          end
        end
      end
      default: rstate_nxt = RIDLE;
    endcase
  end

  // Stage boundary: storage array to registered operand outputs (1-cycle latency).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rstate   <= RIDLE;
      ra       <= '0;
      rb       <= '0;
      rcnt     <= '0;
      RdValid  <= 1'b0;
      RdDone   <= 1'b0;
      DataOut  <= '0;
      DataOut2 <= '0;
    end else begin
      rstate  <= rstate_nxt;
      RdValid <= rd_fire;
      RdDone  <= rd_last;
      if (rd_start_acc) begin
        ra   <= RdAddr;
        rb   <= RdAddr2;
        rcnt <= '0;
      end else if (rd_fire) begin
        DataOut  <= mem[ra][rcnt];
        DataOut2 <= mem[rb][rcnt];
        rcnt     <= rd_last ? '0 : rcnt + 1'b1;
      end
    end
  end

endmodule
